// File: rtl/log2_pkg.sv
// Shared types and default sizing for the log2 stream post-processing blocks.
package log2_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_LOG2_N = 4;
  localparam int DEF_SUM_W  = DEF_WIDTH + DEF_LOG2_N;

  // A window of 2^log2_n samples needs log2_n extra bits to never overflow.
  function automatic int sum_width(input int width, input int log2_n);
    return width + log2_n;
  endfunction

endpackage

// File: rtl/log2_window_avg_if.sv
// Sample stream in, window record stream out, plus the early-close request.
interface log2_window_avg_if import log2_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOG2_N = DEF_LOG2_N
) ();

  localparam int SUM_W = sum_width(WIDTH, LOG2_N);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in0;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out0;
  logic [SUM_W-1:0]  out_sum;
  logic [WIDTH-1:0]  out_min;
  logic [WIDTH-1:0]  out_max;
  logic              out_partial;
  logic [LOG2_N:0]   out_count;

  modport master (
    output in_valid, in0, flush, out_ready,
    input  in_ready, out_valid, out0, out_sum, out_min, out_max, out_partial, out_count
  );

  modport slave (
    input  in_valid, in0, flush, out_ready,
    output in_ready, out_valid, out0, out_sum, out_min, out_max, out_partial, out_count
  );

endinterface

// File: rtl/log2_minmax.sv
// Registered running min/max; next values are exposed so a record can
// include the sample accepted in the same cycle it is latched.
module log2_minmax import log2_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] min_next,
  output logic [WIDTH-1:0] max_next
);

  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;

  // The first sample of a window overrides the stale tracked values.
  always_comb begin
    min_next = min_q;
    max_next = max_q;
    if (en) begin
      if (load || (sample < min_q)) min_next = sample;
      if (load || (sample > max_q)) max_next = sample;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else if (clear) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_next;
      max_q <= max_next;
    end
  end

endmodule

// File: rtl/log2_window_avg.sv
// Accumulates fixed windows of 2^LOG2_N log2 samples and emits one
// sum/average/min/max record per window (or per early flush).
module log2_window_avg import log2_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input logic              clk,
  input logic              rst_n,
  log2_window_avg_if.slave bus
);

  localparam int SUM_W = sum_width(WIDTH, LOG2_N);
  localparam logic [LOG2_N:0] FULL = {1'b1, {LOG2_N{1'b0}}};

  state_t           state;
  state_t           next_state;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_next;
  logic [LOG2_N:0]  count;
  logic [LOG2_N:0]  count_next;
  logic             ready_q;
  logic             valid_q;
  logic             accept;
  logic             latch;
  logic             partial;
  logic             release_rec;
  logic [WIDTH-1:0] min_next;
  logic [WIDTH-1:0] max_next;

  logic [SUM_W-1:0] rec_sum;
  logic [WIDTH-1:0] rec_avg;
  logic [WIDTH-1:0] rec_min;
  logic [WIDTH-1:0] rec_max;
  logic [LOG2_N:0]  rec_count;
  logic             rec_partial;

  assign accept     = bus.in_valid && ready_q && (state == ACC);
  assign sum_next   = sum + (accept ? {{LOG2_N{1'b0}}, bus.in0} : '0);
  assign count_next = count + {{LOG2_N{1'b0}}, accept};

  // A full window wins over a flush arriving on the same cycle.
  always_comb begin
    next_state  = state;
    latch       = 1'b0;
    partial     = 1'b0;
    release_rec = 1'b0;
    case (state)
      ACC: begin
        if (accept && (count_next == FULL)) begin
          latch      = 1'b1;
          next_state = HOLD;
        end else if (bus.flush && (count_next != '0)) begin
          latch      = 1'b1;
          partial    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          release_rec = 1'b1;
          next_state  = ACC;
        end
      end
    endcase
  end

  // Handshake flags are registered from the next state so they stay glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ACC;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == ACC);
      valid_q <= (next_state == HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum   <= '0;
      count <= '0;
    end else if (release_rec) begin
      sum   <= '0;
      count <= '0;
    end else if (accept) begin
      sum   <= sum_next;
      count <= count_next;
    end
  end

  log2_minmax #(
    .WIDTH (WIDTH)
  ) u_minmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (release_rec),
    .en       (accept),
    .load     (count == '0),
    .sample   (bus.in0),
    .min_next (min_next),
    .max_next (max_next)
  );

  // The average always divides by the full window length, even for partial records.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_sum     <= '0;
      rec_avg     <= '0;
      rec_min     <= '0;
      rec_max     <= '0;
      rec_count   <= '0;
      rec_partial <= 1'b0;
    end else if (latch) begin
      rec_sum     <= sum_next;
      rec_avg     <= WIDTH'(sum_next >> LOG2_N);
      rec_min     <= min_next;
      rec_max     <= max_next;
      rec_count   <= count_next;
      rec_partial <= partial;
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = valid_q;
  assign bus.out0        = rec_avg;
  assign bus.out_sum     = rec_sum;
  assign bus.out_min     = rec_min;
  assign bus.out_max     = rec_max;
  assign bus.out_count   = rec_count;
  assign bus.out_partial = rec_partial;

endmodule

// File: tb/tb_log2_window_avg.sv
// Directed and randomized checks of log2_window_avg against a sample-queue model.
module tb_log2_window_avg;
  import log2_pkg::*;

  localparam int WIDTH  = DEF_WIDTH;
  localparam int LOG2_N = DEF_LOG2_N;
  localparam int SUM_W  = DEF_SUM_W;
  localparam int N      = 1 << LOG2_N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  log2_window_avg_if #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) bus ();

  log2_window_avg #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] win[$];
  bit               m_hold;
  bit               m_ready;
  bit               m_valid;
  bit               m_partial;
  logic [SUM_W-1:0] m_sum;
  logic [WIDTH-1:0] m_avg;
  logic [WIDTH-1:0] m_min;
  logic [WIDTH-1:0] m_max;
  logic [LOG2_N:0]  m_count;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic closeWindow(input bit part);
    logic [SUM_W-1:0] s;
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mx;
    s  = '0;
    mn = '1;
    mx = '0;
    foreach (win[i]) begin
      s = s + SUM_W'(win[i]);
      if (win[i] < mn) mn = win[i];
      if (win[i] > mx) mx = win[i];
    end
    m_sum     = s;
    m_avg     = WIDTH'(s / N);
    m_min     = mn;
    m_max     = mx;
    m_count   = (LOG2_N+1)'(win.size());
    m_partial = part;
    m_hold    = 1'b1;
    m_valid   = 1'b1;
  endtask

  task automatic checkAll();
    checkOutput("in_ready",    64'(bus.in_ready),    64'(m_ready));
    checkOutput("out_valid",   64'(bus.out_valid),   64'(m_valid));
    checkOutput("out_sum",     64'(bus.out_sum),     64'(m_sum));
    checkOutput("out0",        64'(bus.out0),        64'(m_avg));
    checkOutput("out_min",     64'(bus.out_min),     64'(m_min));
    checkOutput("out_max",     64'(bus.out_max),     64'(m_max));
    checkOutput("out_count",   64'(bus.out_count),   64'(m_count));
    checkOutput("out_partial", 64'(bus.out_partial), 64'(m_partial));
  endtask

  // One clock: drive inputs, advance the model across the edge, compare after it.
  task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit fl,
                               input bit ordy, output bit acc);
    acc = 1'b0;
    bus.in_valid  = v;
    bus.in0       = d;
    bus.flush     = fl;
    bus.out_ready = ordy;
    if (!rst_n) begin
      win.delete();
      m_hold = 0; m_ready = 0; m_valid = 0; m_partial = 0;
      m_sum = '0; m_avg = '0; m_min = '0; m_max = '0; m_count = '0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold  = 1'b0;
        m_valid = 1'b0;
        m_ready = 1'b1;
        win.delete();
      end
    end else begin
      acc = v && m_ready;
      if (acc) win.push_back(d);
      if (acc && (win.size() == N)) closeWindow(1'b0);
      else if (fl && (win.size() > 0)) closeWindow(1'b1);
      m_ready = !m_hold;
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic sendSample(input logic [WIDTH-1:0] d, input bit fl, input int ordy_pct);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++)
      applyStimulus(1'b1, d, fl, ($urandom_range(99) < ordy_pct), acc);
    checkOutput("accept_bound", 64'(acc), 64'd1);
  endtask

  task automatic idle(input bit fl, input bit ordy);
    bit acc;
    applyStimulus(1'b0, '0, fl, ordy, acc);
  endtask

  task automatic checkRecord(input string tag, input bit vld, input logic [SUM_W-1:0] s,
                             input logic [WIDTH-1:0] avg, input logic [WIDTH-1:0] mn,
                             input logic [WIDTH-1:0] mx, input int cnt, input bit part);
    checkOutput({tag, "_valid"},   64'(bus.out_valid),   64'(vld));
    checkOutput({tag, "_sum"},     64'(bus.out_sum),     64'(s));
    checkOutput({tag, "_avg"},     64'(bus.out0),        64'(avg));
    checkOutput({tag, "_min"},     64'(bus.out_min),     64'(mn));
    checkOutput({tag, "_max"},     64'(bus.out_max),     64'(mx));
    checkOutput({tag, "_count"},   64'(bus.out_count),   64'(cnt));
    checkOutput({tag, "_partial"}, 64'(bus.out_partial), 64'(part));
  endtask

  initial begin
    bit acc;
    logic [WIDTH-1:0] pending;
    bus.in_valid = 0; bus.in0 = '0; bus.flush = 0; bus.out_ready = 1;

    rst_n = 1'b0;
    idle(0, 1);
    idle(0, 1);
    checkRecord("reset", 0, '0, '0, '0, '0, 0, 0);
    rst_n = 1'b1;
    idle(0, 1);

    for (int i = 0; i < N; i++) sendSample(32'd5, 0, 100);
    checkRecord("full5", 1, 36'd80, 32'd5, 32'd5, 32'd5, 16, 0);
    idle(0, 1);

    for (int i = 0; i < N; i++) sendSample(WIDTH'(i), 0, 100);
    checkRecord("ramp0", 1, 36'd120, 32'd7, 32'd0, 32'd15, 16, 0);
    for (int i = 0; i < N; i++) sendSample(WIDTH'(100 + i), 0, 100);
    checkRecord("ramp100", 1, 36'd1720, 32'd107, 32'd100, 32'd115, 16, 0);
    idle(0, 1);

    for (int i = 0; i < N; i++) sendSample($urandom, 0, 100);
    pending = $urandom;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, pending, 1'b0, 1'b0, acc);
    sendSample(pending, 0, 100);
    for (int i = 1; i < N; i++) sendSample($urandom_range(0, 255), 0, 100);
    idle(0, 1);

    sendSample(32'd7, 0, 0);
    sendSample(32'd2, 0, 0);
    sendSample(32'd9, 0, 0);
    idle(1, 0);
    checkRecord("flush3", 1, 36'd18, 32'd1, 32'd2, 32'd9, 3, 1);
    idle(1, 1);
    idle(1, 1);
    idle(1, 1);
    checkOutput("empty_flush_valid", 64'(bus.out_valid), 64'd0);

    sendSample(32'd42, 1, 0);
    checkRecord("flush_one", 1, 36'd42, 32'd2, 32'd42, 32'd42, 1, 1);
    idle(0, 1);
    for (int i = 0; i < N - 1; i++) sendSample(32'd3, 0, 100);
    sendSample(32'd19, 1, 0);
    checkRecord("flush_nth", 1, 36'd64, 32'd4, 32'd3, 32'd19, 16, 0);
    idle(0, 1);

    for (int i = 0; i < N; i++) sendSample(32'hFFFF_FFFF, 0, 100);
    checkRecord("ovf", 1, 36'hF_FFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16, 0);
    idle(0, 1);

    for (int i = 0; i < 8; i++) sendSample(32'd50, 0, 100);
    rst_n = 1'b0;
    idle(0, 1);
    checkRecord("midreset", 0, '0, '0, '0, '0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) sendSample(32'd1, 0, 100);
    checkRecord("after_reset", 1, 36'd16, 32'd1, 32'd1, 32'd1, 16, 0);
    idle(0, 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0)
        idle($urandom_range(3) == 0, $urandom_range(1) == 1);
      else
        sendSample(($urandom_range(1) == 1) ? $urandom : $urandom_range(0, 63),
                   $urandom_range(19) == 0, 70);
    end
    for (int i = 0; i < 3; i++) idle(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/log2_window_avg.md
# log2_window_avg

Streaming post-processor that sits directly downstream of `log2_32b`. It accepts a stream of 32-bit log2 results over a valid/ready handshake, accumulates them in fixed, non-overlapping windows of 2^LOG2_N samples, and emits one record per window: the window sum, the average (sum shifted right by LOG2_N), and the window minimum and maximum. It turns the combinational log2 benchmark into a measurable stream stage (geometric-mean estimation in the log domain).

## Interface
- `WIDTH`, 32, sample width; matches the `log2_32b` output `out0`.
- `LOG2_N`, 4, log2 of the window length (N = 16 samples); legal range 1..8.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: block accepts a sample this cycle.
- `in0` in WIDTH: sample, unsigned, taken directly from `log2_32b` `out0`.
- `out_valid` out 1: window record valid.
- `out_ready` in 1: downstream accepts the record.
- `out0` out WIDTH: window average, sum >> LOG2_N, truncated.
- `out_sum` out WIDTH+LOG2_N: exact window sum.
- `out_min` out WIDTH: smallest sample in the window.
- `out_max` out WIDTH: largest sample in the window.
- `flush` in 1: close the current partial window early.
- `out_partial` out 1: record came from a flush; its count is below N.
- `out_count` out LOG2_N+1: number of samples in the record (1..N).

## Operation
- FSM has two states, ACC and HOLD. Reset enters ACC.
- ACC: `in_ready`=1. A sample is accepted when `in_valid`&&`in_ready`.
  - On accept: sum += in0; min/max updated (the first sample of a window loads both); count++.
  - When the accept makes count N: latch the record, set `out_partial`=0, go to HOLD.
- `flush` in ACC with count>0: latch the record (including a sample accepted in the same cycle), set `out_partial`=1, go to HOLD.
- `flush` with count=0 and no accept in that cycle: ignored.
- If the Nth accept and `flush` occur together: full record with `out_partial`=0.
- HOLD: `in_ready`=0 and `out_valid`=1. Output registers are stable until `out_valid`&&`out_ready`. Then the accumulators clear and the FSM returns to ACC. `flush` is ignored in HOLD.
- Arithmetic:
  - sum is WIDTH+LOG2_N bits and cannot overflow.
  - The average is always sum >> LOG2_N, including for partial windows. Consumers rescale using `out_count`.
  - min/max compare unsigned.
- Reset values: `in_ready`=0 during the reset cycle and 1 afterwards; `out_valid`=0; `out0`, `out_sum`, `out_min`, `out_max`, `out_count` and `out_partial` all 0. Internal accumulators and count are 0.
- Reset mid-window or mid-HOLD discards all state; no record is emitted.

## Timing
- Record latency: `out_valid` rises in the cycle after the Nth accept (or after the flush).
- All outputs are registered; there is no combinational path from `in0` to any output.
- `in_ready` depends only on state, not on `out_ready`. There is therefore one bubble per window: the handshake cycle in HOLD plus a return to ACC.
- Throughput: N samples per N+1 cycles minimum when `out_ready` is held 1.
- `in0` must be stable only in the accept cycle. The valid/ready rules are AXI-stream-like: valid must not drop without a handshake, and the block honours this on its output side.

## Structure
- Shared package `log2_pkg`: the state enum (ACC, HOLD), the default `WIDTH` and `LOG2_N`, and the derived sum width constant.
- One natural sub-module: `log2_minmax`, a registered min/max tracker with a load-first-sample input and a clear input.
- The top level holds the FSM, the accumulator, the counter and the output registers.

## Test plan
- Full window: 16 samples of value 5, with `out_ready`=1.
  - Expect `out_sum`=80, `out0`=5, min=max=5, `out_count`=16, `out_partial`=0.
  - `out_valid` asserts exactly one cycle after the 16th accept.
- Ramp: samples 0..15.
  - Expect `out_sum`=120, `out0`=7, `out_min`=0, `out_max`=15.
  - A second window of samples 100..115 gives `out_sum`=1720, `out0`=107, min=100, max=115.
- Backpressure: hold `out_ready`=0 for 10 cycles after a record.
  - Outputs stay stable, `in_ready`=0, and no samples are lost.
  - After the handshake, the next window starts clean.
- Flush: 3 samples (7, 2, 9), then `flush`.
  - Expect `out_sum`=18, `out0`=1, min=2, max=9, `out_count`=3, `out_partial`=1.
  - A flush with an empty window produces no record.
- Overflow edge: 16 samples of 0xFFFFFFFF.
  - Expect `out_sum`=0xFFFFFFFF0 (36-bit), `out0`=0xFFFFFFFF.
- Reset mid-window: 8 samples, then `rst_n`=0 for one cycle, then 16 samples of 1.
  - Expect a single record with `out_sum`=16 and all reset values as specified.
